// File: rtl/mem_request_arbiter.sv
// Grants the single-ported RAM to data or instruction requests and produces
// the ihit/dhit responses, with a per-access timeout and sticky error flag.
module mem_request_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_rdy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_nxt;
  logic          d_req;
  logic          cnt_expired;

  assign d_req       = dREN | dWEN;
  assign cnt_expired = (cnt == CW'(TIMEOUT - 1));

  // State, timeout counter and sticky error register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= err_nxt;
    end
  end

  // Next-state and RAM-side/hit decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = timeout_err;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;

    unique case (state)
      IDLE: begin
        // Counter is cleared here so every busy entry starts from zero
        cnt_nxt = '0;
        if (d_req) begin
          state_nxt = DBUSY;
        end else if (iREN) begin
          state_nxt = IBUSY;
        end
      end

      IBUSY: begin
        ramaddr = iaddr;
        // Strobe follows iREN so a flush releases the RAM in the same cycle
        ramREN  = iREN;
        if (!iREN) begin
          state_nxt = IDLE;
        end else if (ram_rdy) begin
          ihit      = 1'b1;
          iload     = ramload;
          state_nxt = IDLE;
        end else if (cnt_expired) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      DBUSY: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = dREN;
        end
        if (!d_req) begin
          state_nxt = IDLE;
        end else if (ram_rdy) begin
          dhit      = 1'b1;
          dload     = dWEN ? 32'h0 : ramload;
          state_nxt = IDLE;
        end else if (cnt_expired) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: fetch, contention, flush,
// timeout, write-wins and asynchronous reset scenarios.
module tb_mem_request_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_rdy;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, timeout_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  mem_request_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_rdy(ram_rdy), .timeout_err(timeout_err)
  );

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [133:0] outs;
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      outs = {ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err};
      checks++;
      if (outs !== '0) $display("FAIL reset_hold[%0d]: got %h expected 0", i, outs);
      else passed++;
    end
    next_cycle(); nRST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      outs = {ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err};
      checks++;
      if (outs !== '0) $display("FAIL idle_after_reset[%0d]: got %h expected 0", i, outs);
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_instr_fetch();
    #1; iREN = 1'b1; iaddr = 32'h40; ram_rdy = 1'b0;
    #1; checks++;
    if ({ramREN, ihit} !== 2'b00) $display("FAIL fetch_arb: got %b expected 00", {ramREN, ihit});
    else passed++;
    next_cycle(); #1; checks++;
    if ({ramREN, ramWEN, ihit, ramaddr} !== {3'b100, 32'h40})
      $display("FAIL fetch_busy1: got %h expected %h", {ramREN, ramWEN, ihit, ramaddr}, {3'b100, 32'h40});
    else passed++;
    next_cycle(); ram_rdy = 1'b1; ramload = 32'h8C220004; #1; checks++;
    if ({ramREN, ihit, iload} !== {2'b11, 32'h8C220004})
      $display("FAIL fetch_hit: got %h expected %h", {ramREN, ihit, iload}, {2'b11, 32'h8C220004});
    else passed++;
    next_cycle(); iREN = 1'b0; #1; checks++;
    if ({ramREN, ihit, iload} !== 34'h0)
      $display("FAIL fetch_idle_after: got %h expected 0", {ramREN, ihit, iload});
    else passed++;
    ram_rdy = 1'b0;
  endtask

  task automatic test_contention();
    next_cycle();
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100;
    dstore = 32'hDEADBEEF; ram_rdy = 1'b1; ramload = 32'h12345678;
    #1; checks++;
    if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000)
      $display("FAIL cont_arb_ignores_rdy: got %b expected 0000", {ramREN, ramWEN, ihit, dhit});
    else passed++;
    next_cycle(); #1; checks++;
    if ({ramREN, ramWEN, dhit, ihit, ramaddr, ramstore, dload} !== {4'b0110, 32'h100, 32'hDEADBEEF, 32'h0})
      $display("FAIL cont_write_hit: got %h expected %h", {ramREN, ramWEN, dhit, ihit, ramaddr, ramstore, dload},
               {4'b0110, 32'h100, 32'hDEADBEEF, 32'h0});
    else passed++;
    next_cycle(); dWEN = 1'b0; #1; checks++;
    if ({ramREN, ramWEN, dhit, ihit} !== 4'b0000)
      $display("FAIL cont_idle_gap: got %b expected 0000", {ramREN, ramWEN, dhit, ihit});
    else passed++;
    next_cycle(); ramload = 32'hA5A5_0001; #1; checks++;
    if ({ramREN, ramWEN, ihit, ramaddr, iload} !== {3'b101, 32'h44, 32'hA5A5_0001})
      $display("FAIL cont_fetch_hit: got %h expected %h", {ramREN, ramWEN, ihit, ramaddr, iload},
               {3'b101, 32'h44, 32'hA5A5_0001});
    else passed++;
    next_cycle(); iREN = 1'b0; ram_rdy = 1'b0; #1; checks++;
    if ({ramREN, ihit, dhit} !== 3'b000) $display("FAIL cont_end_idle: got %b expected 000", {ramREN, ihit, dhit});
    else passed++;
  endtask

  task automatic test_flush();
    next_cycle(); iREN = 1'b1; iaddr = 32'h80; ram_rdy = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      next_cycle(); #1; checks++;
      if (ramREN !== 1'b1) $display("FAIL flush_busy%0d_ren: got %b expected 1", i, ramREN);
      else passed++;
    end
    next_cycle(); iREN = 1'b0; #1; checks++;
    if ({ramREN, ihit} !== 2'b00) $display("FAIL flush_drop: got %b expected 00", {ramREN, ihit});
    else passed++;
    next_cycle(); ram_rdy = 1'b1; #1; checks++;
    if ({ramREN, ihit, timeout_err} !== 3'b000)
      $display("FAIL flush_idle: got %b expected 000", {ramREN, ihit, timeout_err});
    else passed++;
    ram_rdy = 1'b0;
  endtask

  task automatic test_timeout();
    next_cycle(); dREN = 1'b1; daddr = 32'h200; ram_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); #1; checks++;
      if ({ramREN, dhit, timeout_err} !== 3'b100)
        $display("FAIL timeout_busy%0d: got %b expected 100", i, {ramREN, dhit, timeout_err});
      else passed++;
    end
    next_cycle(); #1; checks++;
    if ({ramREN, dhit, timeout_err} !== 3'b001)
      $display("FAIL timeout_flag: got %b expected 001", {ramREN, dhit, timeout_err});
    else passed++;
    next_cycle(); ram_rdy = 1'b1; ramload = 32'hCAFEF00D; #1; checks++;
    if ({dhit, dload, timeout_err} !== {1'b1, 32'hCAFEF00D, 1'b1})
      $display("FAIL timeout_sticky_hit: got %h expected %h", {dhit, dload, timeout_err}, {1'b1, 32'hCAFEF00D, 1'b1});
    else passed++;
    next_cycle(); dREN = 1'b0; ram_rdy = 1'b0; #1; checks++;
    if ({dhit, dload, timeout_err} !== {1'b0, 32'h0, 1'b1})
      $display("FAIL timeout_sticky_idle: got %h expected %h", {dhit, dload, timeout_err}, {1'b0, 32'h0, 1'b1});
    else passed++;
  endtask

  task automatic test_write_wins();
    next_cycle(); dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'h0BADF00D;
    next_cycle(); ram_rdy = 1'b1; ramload = 32'h77777777; #1; checks++;
    if ({ramREN, ramWEN, dhit, ramstore, dload} !== {3'b011, 32'h0BADF00D, 32'h0})
      $display("FAIL write_wins: got %h expected %h", {ramREN, ramWEN, dhit, ramstore, dload},
               {3'b011, 32'h0BADF00D, 32'h0});
    else passed++;
    next_cycle(); dWEN = 1'b0; ram_rdy = 1'b0;
    next_cycle(); ram_rdy = 1'b1; ramload = 32'h13572468; #1; checks++;
    if ({ramREN, ramWEN, dhit, ramstore, dload} !== {3'b101, 32'h0, 32'h13572468})
      $display("FAIL data_read: got %h expected %h", {ramREN, ramWEN, dhit, ramstore, dload},
               {3'b101, 32'h0, 32'h13572468});
    else passed++;
    next_cycle(); dREN = 1'b0; ram_rdy = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic [133:0] outs;
    next_cycle(); dREN = 1'b1; daddr = 32'h400; ram_rdy = 1'b0;
    next_cycle(); #1; checks++;
    if (ramREN !== 1'b1) $display("FAIL rst_mid_busy: got %b expected 1", ramREN);
    else passed++;
    ram_rdy = 1'b1; nRST = 1'b0; #1;
    outs = {ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err};
    checks++;
    if (outs !== '0) $display("FAIL rst_mid_outputs: got %h expected 0", outs);
    else passed++;
    next_cycle(); nRST = 1'b1; ramload = 32'h2468ACE0; #1; checks++;
    if ({ramREN, dhit} !== 2'b00) $display("FAIL rst_release_idle: got %b expected 00", {ramREN, dhit});
    else passed++;
    next_cycle(); #1; checks++;
    if ({ramREN, dhit, dload, ramaddr} !== {2'b11, 32'h2468ACE0, 32'h400})
      $display("FAIL rst_resume_hit: got %h expected %h", {ramREN, dhit, dload, ramaddr}, {2'b11, 32'h2468ACE0, 32'h400});
    else passed++;
    next_cycle(); dREN = 1'b0; ram_rdy = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_rdy = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    test_reset();
    test_instr_fetch();
    test_contention();
    test_flush();
    test_timeout();
    test_write_wins();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Arbitrates the pipeline's instruction-fetch and data-memory requests onto the single-ported RAM and generates the `ihit`/`dhit` responses that the hazard unit consumes to drive its enables, stalls and flushes. It sits between the fetch and memory stages on one side and the RAM on the other. It is the responder half of the hit/stall handshake: the hazard unit reads `ihit`/`dhit`, and this block produces them. It contains a three-state grant FSM, a per-access timeout counter and a sticky error flag.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles spent in one busy state waiting for `ram_rdy`. Must be at least 1.
- `CW`, default `$clog2(TIMEOUT+1)`: width of the timeout counter. Derived; not to be overridden.

Ports:
- `CLK`  in  1: system clock. All state updates on the rising edge.
- `nRST`  in  1: reset, asynchronous, active-low.
- `iREN`  in  1: instruction read request. Held by fetch until `ihit`; may be dropped early on a flush.
- `iaddr`  in  32: instruction address.
- `dREN`  in  1: data read request. Held until `dhit`.
- `dWEN`  in  1: data write request. Held until `dhit`.
- `daddr`  in  32: data address.
- `dstore`  in  32: data write word.
- `ihit`  out  1: instruction access complete. `iload` is valid in the same cycle.
- `dhit`  out  1: data access complete. `dload` is valid in the same cycle.
- `iload`  out  32: fetched instruction word.
- `dload`  out  32: loaded data word.
- `ramREN`  out  1: RAM read strobe.
- `ramWEN`  out  1: RAM write strobe.
- `ramaddr`  out  32: RAM address.
- `ramstore`  out  32: RAM write data.
- `ramload`  in  32: RAM read data. Valid when `ram_rdy` is high.
- `ram_rdy`  in  1: RAM access complete this cycle.
- `timeout_err`  out  1: sticky flag; a RAM access exceeded `TIMEOUT` cycles.

## Operation
- FSM states: IDLE, IBUSY, DBUSY.
  - All RAM-side outputs and all hits are combinational decodes of state, `ram_rdy` and the request inputs.
- IDLE:
  - No RAM strobe is driven. All outputs are 0, except `timeout_err`, which holds its value.
  - Next state: DBUSY if `dREN|dWEN`; else IBUSY if `iREN`; else stay in IDLE.
  - Data requests have fixed priority over instruction requests.
- IBUSY:
  - Outputs: `ramREN=1`, `ramaddr=iaddr`, `ramWEN=0`, `ramstore=0`.
  - If `ram_rdy`: `ihit=1`, `iload=ramload`, next state IDLE.
  - If `iREN` drops (flush): next state IDLE, no hit. The RAM strobe drops in that same cycle.
- DBUSY:
  - Outputs: `ramaddr=daddr`.
  - If `dWEN`: `ramWEN=1`, `ramstore=dstore`, `ramREN=0`. If `dWEN` and `dREN` are both high, the write wins.
  - Otherwise: `ramREN=1`, `ramstore=0`.
  - If `ram_rdy`: `dhit=1`; `dload=ramload` for a read, 0 for a write; next state IDLE.
  - Data requests cannot be abandoned. Dropping `dREN`/`dWEN` while in DBUSY is a protocol violation; the block returns to IDLE without a hit.
- `iload` is 0 whenever `ihit` is 0, and `dload` is 0 whenever `dhit` is 0. No stale data ever appears on these outputs.
- Timeout counter:
  - Cleared on every entry to a busy state.
  - Increments each busy cycle in which `ram_rdy` is 0.
  - When the count reaches `TIMEOUT` with `ram_rdy` still 0: set `timeout_err`, go to IDLE, assert no hit.
  - `timeout_err` is cleared only by `nRST`.
- `ram_rdy` while in IDLE is ignored.

## Timing
- Reset values: state IDLE, counter 0, `timeout_err` 0. All outputs are therefore 0 during and immediately after reset.
- Reset asserted mid-access: the FSM returns to IDLE immediately (asynchronously) and no hit is issued.
- Access latency from a request rising in IDLE:
  - 1 arbitration cycle, then the RAM strobe appears in the next cycle.
  - The hit occurs in the first busy cycle that has `ram_rdy=1`.
  - Minimum is 2 cycles, request-high to hit.
- After any hit the FSM spends exactly one cycle in IDLE before granting again. So back-to-back accesses take at least 2 cycles each.
- Simultaneous `iREN` and `dREN`/`dWEN` in IDLE: DBUSY first. IBUSY is entered on the cycle after the IDLE that follows `dhit`, provided `iREN` is still high.
- Timeout: with `TIMEOUT=T` and `ram_rdy` held at 0, the FSM leaves the busy state after T busy cycles. `timeout_err` is visible from the following cycle.

## Test plan
- Reset then idle: hold `nRST=0` for 2 cycles, then release with no requests → every output stays 0 for 10 cycles.
- Instruction fetch:
  - Stimulus: `iREN=1`, `iaddr=0x40`. RAM returns `ram_rdy` on the 2nd busy cycle with `ramload=0x8C220004`.
  - Response: `ramREN=1` and `ramaddr=0x40` from cycle 1. `ihit=1` with `iload=0x8C220004` on cycle 2 of busy. IDLE the next cycle.
- Contention:
  - Stimulus: `iREN=1`, `iaddr=0x44`, and at the same time `dWEN=1`, `daddr=0x100`, `dstore=0xDEADBEEF`. RAM is ready on the 1st busy cycle.
  - Response: `ramWEN=1` with `ramaddr=0x100` first, then `dhit`, then one IDLE cycle, then `ramREN` with `ramaddr=0x44`, then `ihit`.
- Flush abandon: `iREN` dropped in the 3rd IBUSY cycle while `ram_rdy=0` → `ramREN` falls in that same cycle; no `ihit`; FSM is back in IDLE.
- Timeout: `TIMEOUT=4`, `dREN=1`, `ram_rdy` held at 0 → IDLE after 4 busy cycles; `timeout_err=1` and remains 1 through later successful accesses until `nRST`.
- Reset mid-access: pull `nRST` low during DBUSY → all outputs are 0 immediately; the FSM resumes from IDLE after release.
